// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the register file write port, fed by the ALU and load paths.
// Define WBQ_FWD_EN to build the youngest-match forwarding lookup; otherwise the fwd_* outputs are tied to 0.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     reg_write_enable,
  output logic [ADDR_W-1:0]        reg_write_address,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        read_register_1,
  input  logic [ADDR_W-1:0]        read_register_2,
  output logic                     fwd_hit_1,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic                     fwd_hit_2,
  output logic [DATA_W-1:0]        fwd_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ROOM2_CNT = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  alu_slot;
  logic              mem_push;
  logic              alu_push;
  logic              pop;

  // Ready looks only at the registered count; a same-cycle drain earns no credit.
  assign mem_ready = (count < FULL_CNT);
  assign alu_ready = (count <= ROOM2_CNT) || ((count == LAST_CNT) && !mem_valid);

  // r0 writes complete the handshake but are never stored.
  assign mem_push = mem_valid && mem_ready && (mem_addr != '0);
  assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
  assign pop      = (count != '0);
  assign alu_slot = mem_push ? wr_ptr + PTR_W'(1) : wr_ptr;

  assign reg_write_enable  = pop;
  assign reg_write_address = pop ? addr_q[rd_ptr] : '0;
  assign write_data        = pop ? data_q[rd_ptr] : '0;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop)      valid_q[rd_ptr]   <= 1'b0;
      if (mem_push) valid_q[wr_ptr]   <= 1'b1;
      if (alu_push) valid_q[alu_slot] <= 1'b1;
      wr_ptr <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // NOTE: entry storage is not reset; valid_q and count decide what is live, and the drain outputs are masked.
  always_ff @(posedge clock) begin
    if (mem_push) begin
      addr_q[wr_ptr] <= mem_addr;
      data_q[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

`ifdef WBQ_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk from oldest to youngest so the last match assigned is the youngest.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    fwd_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (valid_q[fwd_idx] && (read_register_1 != '0) && (addr_q[fwd_idx] == read_register_1)) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = data_q[fwd_idx];
      end
      if (valid_q[fwd_idx] && (read_register_2 != '0) && (addr_q[fwd_idx] == read_register_2)) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{read_register_1, read_register_2, valid_q};
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue (DEPTH=4): drain latency, ordering, backpressure, r0, forwarding, reset.
module tb_regfile_writeback_queue;

  logic        clock;
  logic        Reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] write_data;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic        fwd_hit_1;
  logic [31:0] fwd_data_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data_2;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  regfile_writeback_queue dut (
    .clock            (clock),
    .Reset            (Reset),
    .alu_valid        (alu_valid),
    .alu_addr         (alu_addr),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .mem_valid        (mem_valid),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .mem_ready        (mem_ready),
    .reg_write_enable (reg_write_enable),
    .reg_write_address(reg_write_address),
    .write_data       (write_data),
    .read_register_1  (read_register_1),
    .read_register_2  (read_register_2),
    .fwd_hit_1        (fwd_hit_1),
    .fwd_data_1       (fwd_data_1),
    .fwd_hit_2        (fwd_hit_2),
    .fwd_data_2       (fwd_data_2),
    .count            (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
  endtask

  task automatic check_head(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_we"},   32'(reg_write_enable), 32'd1);
    check({tag, "_addr"}, 32'(reg_write_address), 32'(addr));
    check({tag, "_data"}, write_data, data);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    read_register_1 = '0;
    read_register_2 = '0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;

    // Reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_we",    32'(reg_write_enable), 32'd0);
    check("rst_addr",  32'(reg_write_address), 32'd0);
    check("rst_data",  write_data, 32'd0);
    check("rst_alu_rdy", 32'(alu_ready), 32'd1);
    check("rst_mem_rdy", 32'(mem_ready), 32'd1);
    check("rst_hit1",  32'(fwd_hit_1), 32'd0);
    check("rst_hit2",  32'(fwd_hit_2), 32'd0);

    // 1: single ALU write, written one cycle later
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    check("t1_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t1_count", 32'(count), 32'd1);
    check_head("t1_head", 5'd5, 32'hDEAD_BEEF);
    tick();
    check("t1_we_after", 32'(reg_write_enable), 32'd0);
    check("t1_count_after", 32'(count), 32'd0);

    // 2: mem and ALU together, mem is older
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
    #1;
    check("t2_mem_rdy", 32'(mem_ready), 32'd1);
    check("t2_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t2_count0", 32'(count), 32'd2);
    check_head("t2_w0", 5'd3, 32'h11);
    tick();
    check("t2_count1", 32'(count), 32'd1);
    check_head("t2_w1", 5'd4, 32'h22);
    tick();
    check("t2_count2", 32'(count), 32'd0);

    // 3: both valid every cycle; pointers wrap during this test
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h10A;
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h114;
    #1;
    check("t3_c0_count", 32'(count), 32'd0);
    check("t3_c0_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    mem_addr = 5'd11; mem_data = 32'h10B;
    alu_addr = 5'd21; alu_data = 32'h115;
    #1;
    check("t3_c1_count", 32'(count), 32'd2);
    check("t3_c1_alu_rdy", 32'(alu_ready), 32'd1);
    check("t3_c1_mem_rdy", 32'(mem_ready), 32'd1);
    check_head("t3_c1_head", 5'd10, 32'h10A);
    tick();
    mem_addr = 5'd12; mem_data = 32'h10C;
    alu_addr = 5'd22; alu_data = 32'h116;
    #1;
    check("t3_c2_count", 32'(count), 32'd3);
    check("t3_c2_mem_rdy", 32'(mem_ready), 32'd1);
    check("t3_c2_alu_rdy", 32'(alu_ready), 32'd0);
    check_head("t3_c2_head", 5'd20, 32'h114);
    tick();
    idle_inputs();
    #1;
    check("t3_c3_alu_rdy_idle", 32'(alu_ready), 32'd1);
    check("t3_c3_count", 32'(count), 32'd3);
    check_head("t3_d0", 5'd11, 32'h10B);
    tick();
    check("t3_d1_count", 32'(count), 32'd2);
    check_head("t3_d1", 5'd21, 32'h115);
    tick();
    check("t3_d2_count", 32'(count), 32'd1);
    check_head("t3_d2", 5'd12, 32'h10C);
    tick();
    check("t3_d3_count", 32'(count), 32'd0);
    check("t3_d3_we", 32'(reg_write_enable), 32'd0);

    // 4: ALU write to r0 is accepted and discarded
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFF;
    #1;
    check("t4_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("t4_count", 32'(count), 32'd0);
    check("t4_we", 32'(reg_write_enable), 32'd0);

    // 5: forwarding of the youngest pending r7 value
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h2;
    read_register_1 = 5'd7;
    read_register_2 = 5'd9;
    tick();
    idle_inputs();
    #1;
    check("t5_count", 32'(count), 32'd2);
    check_head("t5_head", 5'd7, 32'h1);
`ifdef WBQ_FWD_EN
    check("t5_hit1", 32'(fwd_hit_1), 32'd1);
    check("t5_data1", fwd_data_1, 32'h2);
`else
    check("t5_hit1", 32'(fwd_hit_1), 32'd0);
    check("t5_data1", fwd_data_1, 32'h0);
`endif
    check("t5_hit2", 32'(fwd_hit_2), 32'd0);
    check("t5_data2", fwd_data_2, 32'h0);
    read_register_2 = 5'd0;
    tick();
    check("t5b_count", 32'(count), 32'd1);
`ifdef WBQ_FWD_EN
    check("t5b_hit1", 32'(fwd_hit_1), 32'd1);
    check("t5b_data1", fwd_data_1, 32'h2);
`else
    check("t5b_hit1", 32'(fwd_hit_1), 32'd0);
`endif
    check("t5b_hit2_r0", 32'(fwd_hit_2), 32'd0);
    tick();
    check("t5c_hit1_empty", 32'(fwd_hit_1), 32'd0);
    check("t5c_data1_empty", fwd_data_1, 32'h0);
    read_register_1 = 5'd0;

    // 6: reset with three writes pending drops them all
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hA2;
    tick();
    mem_addr = 5'd3; mem_data = 32'hA3;
    alu_addr = 5'd4; alu_data = 32'hA4;
    tick();
    idle_inputs();
    #1;
    check("t6_count_pre", 32'(count), 32'd3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("t6_count_rst", 32'(count), 32'd0);
    check("t6_we_rst", 32'(reg_write_enable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_we_after", 32'(reg_write_enable), 32'd0);
      check("t6_count_after", 32'(count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
